// File: rtl/mvm_uart_system.sv
// mvm_uart_system: UART-fed signed y = K*x engine returning each y[r] as W_Y_OUT-bit bytes; `define MVM_UART_STOP_CHECK_EN drops bytes with a low stop bit.
module mvm_uart_system #(
  parameter int CLOCKS_PER_PULSE = 20833,
  parameter int BITS_PER_WORD = 8,
  parameter int PACKET_SIZE_TX = BITS_PER_WORD + 5,
  parameter int R = 3,
  parameter int C = 4,
  parameter int W_X = 8,
  parameter int W_K = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic rx,
  output logic tx
);
  localparam int W_Y_OUT = 32;
  localparam int W_Y = W_X + W_K + $clog2(C);
  localparam int W_BUS_KX = R*C*W_K + C*W_X;
  localparam int N_WORDS_KX = W_BUS_KX / BITS_PER_WORD;
  localparam int W_BUS_Y = R*W_Y_OUT;
  localparam int N_WORDS_Y = W_BUS_Y / BITS_PER_WORD;
  localparam int W_CNT = $clog2(CLOCKS_PER_PULSE + 1);
  localparam int W_BIT = $clog2(PACKET_SIZE_TX + 1);
  localparam int W_KXC = $clog2(N_WORDS_KX + 1);
  localparam int W_YC = $clog2(N_WORDS_Y + 1);
  localparam int W_ROW = $clog2(R + 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic {T_IDLE, T_SEND} tx_state_t;

  rx_state_t r_rx_state, w_rx_next;
  tx_state_t r_tx_state, w_tx_next;
  logic r_rx_s1, r_rx_s2;
  logic [W_CNT-1:0] r_rx_cnt, r_tx_cnt;
  logic [W_BIT-1:0] r_rx_bit, r_tx_bit;
  logic [BITS_PER_WORD-1:0] r_rx_byte;
  logic w_rx_tick, w_rx_valid;
  logic [W_KXC-1:0] r_kx_cnt;
  logic [W_BUS_KX-BITS_PER_WORD-1:0] r_kx_sh;
  logic [W_BUS_KX-1:0] w_kx_full, r_kx, r_pend;
  logic w_kx_done, r_pend_v;
  logic r_comp, r_y_v;
  logic [W_ROW-1:0] r_row;
  logic [W_BUS_Y-1:0] r_y;
  logic signed [W_Y-1:0] w_acc;
  logic w_free, w_src_pend, w_src_new;
  logic [W_YC-1:0] r_tx_idx, w_tx_sel;
  logic [PACKET_SIZE_TX-1:0] r_tx_sh, w_tx_frame;
  logic w_tx_start, w_bit_end, w_frame_end, w_tx_done;

  assign w_rx_tick = (r_rx_state == R_START) ? (r_rx_cnt == W_CNT'(CLOCKS_PER_PULSE/2 - 1))
                                             : (r_rx_cnt == W_CNT'(CLOCKS_PER_PULSE - 1));
`ifdef MVM_UART_STOP_CHECK_EN
  assign w_rx_valid = r_rx_state == R_STOP && w_rx_tick && r_rx_s2;
`else
  assign w_rx_valid = r_rx_state == R_STOP && w_rx_tick;
`endif

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_rx_state <= R_IDLE;
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_state <= w_rx_next;
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      R_IDLE:  if (!r_rx_s2) w_rx_next = R_START;
      R_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? R_IDLE : R_DATA;
      R_DATA:  if (w_rx_tick && r_rx_bit == W_BIT'(BITS_PER_WORD - 1)) w_rx_next = R_STOP;
      R_STOP:  if (w_rx_tick) w_rx_next = R_IDLE;
      default: w_rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn || r_rx_state == R_IDLE || w_rx_tick) r_rx_cnt <= '0;
    else r_rx_cnt <= r_rx_cnt + 1'b1;
    if (rstn || r_rx_state != R_DATA) r_rx_bit <= '0;
    else if (w_rx_tick) r_rx_bit <= r_rx_bit + 1'b1;
    if (rstn) r_rx_byte <= '0;
    else if (r_rx_state == R_DATA && w_rx_tick) r_rx_byte <= {r_rx_s2, r_rx_byte[BITS_PER_WORD-1:1]};
  end

  assign w_kx_full = {r_rx_byte, r_kx_sh};
  assign w_kx_done = w_rx_valid && r_kx_cnt == W_KXC'(N_WORDS_KX - 1);

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_kx_cnt <= '0;
      r_kx_sh <= '0;
    end else if (w_rx_valid) begin
      r_kx_cnt <= w_kx_done ? '0 : r_kx_cnt + 1'b1;
      r_kx_sh <= w_kx_full[W_BUS_KX-1:BITS_PER_WORD];
    end
  end

  assign w_free = !r_comp && !r_y_v && (r_tx_state == T_IDLE || w_tx_done);
  assign w_src_pend = w_free && r_pend_v;
  assign w_src_new = w_free && !r_pend_v && w_kx_done;

  always_comb begin
    w_acc = '0;
    for (int c = 0; c < C; c++)
      w_acc = w_acc + W_Y'($signed(r_kx[c*W_X +: W_X]) * $signed(r_kx[C*W_X + (int'(r_row)*C + c)*W_K +: W_K]));
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_kx <= '0;
      r_pend <= '0;
      r_pend_v <= 1'b0;
      r_comp <= 1'b0;
      r_y_v <= 1'b0;
      r_row <= '0;
      r_y <= '0;
    end else begin
      if (w_src_pend || w_src_new) begin
        r_kx <= w_src_pend ? r_pend : w_kx_full;
        r_comp <= 1'b1;
        r_row <= '0;
      end else if (r_comp) begin
        r_y[int'(r_row)*W_Y_OUT +: W_Y_OUT] <= W_Y_OUT'(w_acc);
        r_row <= r_row + 1'b1;
        if (r_row == W_ROW'(R - 1)) begin
          r_comp <= 1'b0;
          r_y_v <= 1'b1;
        end
      end
      if (w_tx_start) r_y_v <= 1'b0;
      if (w_kx_done && !w_src_new) begin
        r_pend <= w_kx_full;
        r_pend_v <= 1'b1;
      end else if (w_src_pend) r_pend_v <= 1'b0;
    end
  end

  assign w_tx_start = r_tx_state == T_IDLE && r_y_v;
  assign w_bit_end = r_tx_cnt == W_CNT'(CLOCKS_PER_PULSE - 1);
  assign w_frame_end = w_bit_end && r_tx_bit == W_BIT'(PACKET_SIZE_TX - 1);
  assign w_tx_done = r_tx_state == T_SEND && w_frame_end && r_tx_idx == W_YC'(N_WORDS_Y - 1);
  assign w_tx_sel = w_tx_start ? '0 : r_tx_idx + 1'b1;
  assign w_tx_frame = {{(PACKET_SIZE_TX-BITS_PER_WORD-1){1'b1}}, r_y[int'(w_tx_sel)*BITS_PER_WORD +: BITS_PER_WORD], 1'b0};
  assign tx = r_tx_sh[0];

  always_ff @(posedge clk) r_tx_state <= rstn ? T_IDLE : w_tx_next;

  always_comb begin
    w_tx_next = r_tx_state;
    if (w_tx_start) w_tx_next = T_SEND;
    else if (w_tx_done) w_tx_next = T_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_tx_sh <= '1;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_idx <= '0;
    end else if (w_tx_start) begin
      r_tx_sh <= w_tx_frame;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_idx <= '0;
    end else if (r_tx_state == T_SEND) begin
      r_tx_cnt <= w_bit_end ? '0 : r_tx_cnt + 1'b1;
      if (w_frame_end) begin
        r_tx_bit <= '0;
        r_tx_idx <= w_tx_sel;
        r_tx_sh <= w_tx_done ? '1 : w_tx_frame;
      end else if (w_bit_end) begin
        r_tx_bit <= r_tx_bit + 1'b1;
        r_tx_sh <= {1'b1, r_tx_sh[PACKET_SIZE_TX-1:1]};
      end
    end
  end
endmodule

// File: tb/tb_mvm_uart_system.sv
// tb_mvm_uart_system: scoreboard bench driving UART input sets and decoding the tx response stream.
module tb_mvm_uart_system;
  localparam int CPP = 4;
  localparam int R = 3;
  localparam int C = 4;
  localparam int NB = R*C + C;
  localparam int PERIOD = 10;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic rx = 1'b1;
  logic tx;
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] bs[NB];
  logic [7:0] exp_basic[12] = '{8'hAE, 8'h00, 8'h00, 8'h00, 8'h48, 8'h01, 8'h00, 8'h00, 8'h4F, 8'h01, 8'h00, 8'h00};
  bit mon_busy = 1'b0;
  bit arm = 1'b0;
  time stop_t = 0;
  time first_tx_t = 0;

  mvm_uart_system #(.CLOCKS_PER_PULSE(CPP)) dut (.clk(clk), .rstn(rstn), .rx(rx), .tx(tx));

  always #(PERIOD/2) clk = ~clk;

  initial begin : monitor
    logic [7:0] b;
    logic [7:0] e;
    bit pad_ok;
    forever begin
      @(negedge tx);
      if (arm) begin
        first_tx_t = $time;
        arm = 1'b0;
      end
      mon_busy = 1'b1;
      repeat (CPP/2) @(negedge clk);
      n_checks++;
      if (tx !== 1'b0) begin
        n_errors++;
        $display("FAIL start_bit: got %b want 0", tx);
      end
      for (int i = 0; i < 8; i++) begin
        repeat (CPP) @(negedge clk);
        b[i] = tx;
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_byte: got %02h want no byte", b);
      end else begin
        e = exp_q.pop_front();
        if (b !== e) begin
          n_errors++;
          $display("FAIL tx_byte: got %02h want %02h", b, e);
        end
      end
      pad_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
        repeat (CPP) @(negedge clk);
        if (tx !== 1'b1) pad_ok = 1'b0;
      end
      n_checks++;
      if (!pad_ok) begin
        n_errors++;
        $display("FAIL pad_bits: got a low padding bit want 4 high bits");
      end
      mon_busy = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] v, input logic stop);
    rx = 1'b0;
    repeat (CPP) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      repeat (CPP) @(negedge clk);
    end
    stop_t = $time;
    rx = stop;
    repeat (CPP) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_set(input int gap_lo, input int gap_hi);
    for (int i = 0; i < NB; i++) begin
      if (i == NB - 1) arm = 1'b1;
      send_byte(bs[i], 1'b1);
      repeat ($urandom_range(gap_hi, gap_lo)) @(negedge clk);
    end
  endtask

  task automatic push_model();
    int y;
    for (int r = 0; r < R; r++) begin
      y = 0;
      for (int c = 0; c < C; c++) y += $signed(bs[c]) * $signed(bs[C + r*C + c]);
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(y >> (8*i)));
    end
  endtask

  task automatic push_basic();
    for (int i = 0; i < 12; i++) exp_q.push_back(exp_basic[i]);
  endtask

  task automatic load_basic();
    bs = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd7, 8'd5, 8'd3, 8'd1, 8'd15, 8'd1, 8'd2, 8'd11, 8'd12, 8'd6, 8'd7, 8'd5};
  endtask

  task automatic wait_drain(output bit ok);
    int k = 0;
    while ((exp_q.size() != 0 || mon_busy) && k < 4000) begin
      @(negedge clk);
      k++;
    end
    ok = exp_q.size() == 0 && !mon_busy;
    repeat (80) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_tx: got %b want 1", tx);
    end
    rstn = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (tx !== 1'b1 || mon_busy) begin
      n_errors++;
      $display("FAIL idle_tx: got tx=%b busy=%0d want tx=1 busy=0", tx, mon_busy);
    end
  endtask

  task automatic test_basic();
    bit ok;
    load_basic();
    push_basic();
    send_set(1, 20);
    wait_drain(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL basic_drain: got %0d bytes outstanding want 0", exp_q.size());
    end
    n_checks++;
    if (first_tx_t <= stop_t || first_tx_t - stop_t > 13*PERIOD) begin
      n_errors++;
      $display("FAIL latency: got %0t want within (0,%0d]", first_tx_t - stop_t, 13*PERIOD);
    end
  endtask

  task automatic test_negative();
    bit ok;
    for (int i = 0; i < NB; i++) bs[i] = (i < C) ? 8'hFF : 8'h01;
    push_model();
    send_set(1, 5);
    wait_drain(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL negative_drain: got %0d bytes outstanding want 0", exp_q.size());
    end
  endtask

  task automatic test_max();
    bit ok;
    for (int i = 0; i < NB; i++) bs[i] = 8'h80;
    push_model();
    send_set(1, 5);
    wait_drain(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL max_drain: got %0d bytes outstanding want 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < NB; i++) bs[i] = 8'($urandom);
      push_model();
      send_set(0, 0);
    end
    wait_drain(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL back_to_back_drain: got %0d bytes outstanding want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_rx();
    bit ok;
    load_basic();
    for (int i = 0; i < 5; i++) send_byte(bs[i], 1'b1);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (tx !== 1'b1) begin
        n_errors++;
        $display("FAIL reset_mid_rx_tx: got %b want 1", tx);
      end
    end
    rstn = 1'b0;
    repeat (5) @(negedge clk);
    push_basic();
    send_set(1, 5);
    wait_drain(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL reset_mid_rx_drain: got %0d bytes outstanding want 0", exp_q.size());
    end
  endtask

  task automatic test_stop_bit();
    bit ok;
    load_basic();
    push_basic();
    for (int i = 0; i < NB; i++) begin
`ifdef MVM_UART_STOP_CHECK_EN
      if (i == 3) begin
        send_byte(8'hA5, 1'b0);
        repeat (10) @(negedge clk);
      end
      send_byte(bs[i], 1'b1);
`else
      send_byte(bs[i], i != 3);
      if (i == 3) repeat (10) @(negedge clk);
`endif
      repeat (2) @(negedge clk);
    end
    wait_drain(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL stop_bit_drain: got %0d bytes outstanding want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_max();
    test_back_to_back();
    test_reset_mid_rx();
    test_stop_bit();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL final_queue: got %0d bytes outstanding want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #(2000000);
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
